// File: rtl/fpga_io_pkg.sv
// rtl/fpga_io_pkg.sv - shared constants for the FPGA I/O button debouncer
// Purpose: debounce FSM state encodings, default timing constants and a
//          state-to-level decode helper shared by the top and channel modules.
package fpga_io_pkg;

    localparam logic [1:0] S_REL = 2'd0;    // stable released
    localparam logic [1:0] V_PRS = 2'd1;    // verifying a press
    localparam logic [1:0] S_PRS = 2'd2;    // stable pressed
    localparam logic [1:0] V_REL = 2'd3;    // verifying a release

    localparam int DEF_TICK_DIV     = 1000;
    localparam int DEF_STABLE_TICKS = 20;

    // The debounced level is "pressed" in the stable-pressed state and while a
    // release is still being verified.
    function automatic logic is_pressed(input logic [1:0] st);
        return (st == S_PRS) || (st == V_REL);
    endfunction

endpackage

// File: rtl/fpga_button_debounce_if.sv
// rtl/fpga_button_debounce_if.sv - button pin / debounced event bundle
// Purpose: groups raw pins and debounced outputs of fpga_button_debounce.
// Signals: btn_raw (raw pins), btn_db (clean level), btn_press / btn_release
//          (one-cycle edge pulses), tick (sample strobe).
// Modports: master = pin source / event consumer, slave = debouncer.
interface fpga_button_debounce_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_db;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic               tick;

    modport master (
        output btn_raw,
        input  btn_db,
        input  btn_press,
        input  btn_release,
        input  tick
    );

    modport slave (
        input  btn_raw,
        output btn_db,
        output btn_press,
        output btn_release,
        output tick
    );
endinterface

// File: rtl/fpga_debounce_chan.sv
// rtl/fpga_debounce_chan.sv - one button: synchroniser, debounce FSM, pulses
// Ports: i_clk, i_rst_n (async active-low), i_tick (shared sample strobe),
//        i_raw (raw pin), o_db (debounced level), o_press / o_release
//        (one-cycle pulses in the first cycle o_db shows its new value).
module fpga_debounce_chan
    import fpga_io_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter bit INVERT       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_db,
    output logic o_press,
    output logic o_release
);

    localparam int            CW     = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS);

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          r_release;

    logic          w_s;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;

    // Sync flops reset to INVERT so the post-inversion sample starts released.
    assign w_s       = r_sync2 ^ INVERT;
    assign w_cnt_inc = r_cnt + C_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_tick) begin
            case (r_state)
                S_REL: begin
                    if (w_s) begin
                        if (STABLE_TICKS == 1) begin
                            w_state_nxt = S_PRS;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = V_PRS;
                            w_cnt_nxt   = C_ONE;
                        end
                    end
                end
                V_PRS: begin
                    if (!w_s) begin
                        w_state_nxt = S_REL;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == C_LAST) begin
                        w_state_nxt = S_PRS;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                S_PRS: begin
                    if (!w_s) begin
                        if (STABLE_TICKS == 1) begin
                            w_state_nxt = S_REL;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = V_REL;
                            w_cnt_nxt   = C_ONE;
                        end
                    end
                end
                V_REL: begin
                    if (w_s) begin
                        w_state_nxt = S_PRS;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == C_LAST) begin
                        w_state_nxt = S_REL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_REL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= INVERT;
            r_sync2   <= INVERT;
            r_state   <= S_REL;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            // Pulses load on the same edge as the state, so they line up with
            // the first cycle of the new debounced level.
            r_press   <= is_pressed(w_state_nxt) & ~is_pressed(r_state);
            r_release <= ~is_pressed(w_state_nxt) & is_pressed(r_state);
        end
    end

    assign o_db      = is_pressed(r_state);
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/fpga_button_debounce.sv
// rtl/fpga_button_debounce.sv - multi-button debouncer with shared prescaler
// Ports: PCLK (sole clock), PRESETn (async active-low reset),
//        bus (slave modport: btn_raw in; btn_db, btn_press, btn_release,
//        tick out).
module fpga_button_debounce
    import fpga_io_pkg::*;
#(
    parameter int NUM_BTN      = 2,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter bit INVERT       = 1'b0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    fpga_button_debounce_if.slave bus
);

    localparam int            DW     = $clog2(TICK_DIV);
    localparam logic [DW-1:0] C_DMAX = DW'(TICK_DIV - 1);

    logic [DW-1:0]      r_div;
    logic               w_tick;
    logic [NUM_BTN-1:0] w_db;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;

    // Free-running prescaler; tick is decoded combinationally from it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_div <= '0;
        end else if (r_div == C_DMAX) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    assign w_tick = (r_div == C_DMAX);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        fpga_debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .INVERT       (INVERT)
        ) u_chan (
            .i_clk     (PCLK),
            .i_rst_n   (PRESETn),
            .i_tick    (w_tick),
            .i_raw     (bus.btn_raw[g]),
            .o_db      (w_db[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

    assign bus.btn_db      = w_db;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.tick        = w_tick;

endmodule

// File: tb/tb_fpga_button_debounce.sv
// tb/tb_fpga_button_debounce.sv - self-checking bench for fpga_button_debounce
module tb_fpga_button_debounce;

    localparam int TD = 4;
    localparam int ST = 3;

    logic PCLK;
    logic PRESETn;

    fpga_button_debounce_if #(.NUM_BTN(2)) if0 ();
    fpga_button_debounce_if #(.NUM_BTN(2)) if1 ();

    fpga_button_debounce #(.NUM_BTN(2), .TICK_DIV(TD), .STABLE_TICKS(ST), .INVERT(1'b0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(if0)
    );
    fpga_button_debounce #(.NUM_BTN(2), .TICK_DIV(TD), .STABLE_TICKS(ST), .INVERT(1'b1)) dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(if1)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    // Reference model: the sample seen by the filter is the pin value two
    // edges old; a level flips once ST consecutive tick samples disagree.
    int         m_edges;
    logic [1:0] m_s1, m_s2, m_db, m_press, m_rel;
    int         m_run [2];

    logic [6:0] got0, got1;
    assign got0 = {if0.tick, if0.btn_db, if0.btn_press, if0.btn_release};
    assign got1 = {if1.tick, if1.btn_db, if1.btn_press, if1.btn_release};

    function automatic logic [6:0] expv();
        logic t;
        t = PRESETn && ((m_edges % TD) == TD - 1);
        return {t, m_db, m_press, m_rel};
    endfunction

    task automatic mreset();
        m_edges = 0;
        m_s1 = 2'b00; m_s2 = 2'b00;
        m_db = 2'b00; m_press = 2'b00; m_rel = 2'b00;
        m_run[0] = 0; m_run[1] = 0;
    endtask

    task automatic step(input logic [1:0] raw);
        bit tk;
        if0.btn_raw = raw;
        if1.btn_raw = ~raw;
        @(posedge PCLK);
        if (PRESETn) begin
            tk = ((m_edges % TD) == TD - 1);
            m_press = 2'b00;
            m_rel   = 2'b00;
            if (tk) begin
                for (int b = 0; b < 2; b++) begin
                    if (m_s2[b] != m_db[b]) begin
                        m_run[b]++;
                        if (m_run[b] == ST) begin
                            m_db[b] = ~m_db[b];
                            if (m_db[b]) m_press[b] = 1'b1;
                            else         m_rel[b]   = 1'b1;
                            m_run[b] = 0;
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
            m_edges++;
        end
        #1;
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        mreset();
        step(2'b00);
        step(2'b00);
        PRESETn = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        PRESETn = 1'b0;
        mreset();
        if0.btn_raw = 2'b11;
        if1.btn_raw = 2'b00;
        #1;
        if (got0 !== 7'd0 || got1 !== 7'd0) begin
            bad++; $display("FAIL reset_async got0=%b got1=%b exp=0", got0, got1);
        end
        total++;
        for (int i = 0; i < 4; i++) begin
            step(2'b11);
            e = expv();
            if (got0 !== e || got1 !== e) begin
                bad++; $display("FAIL reset_hold i=%0d got0=%b got1=%b exp=%b", i, got0, got1, e);
            end
            total++;
        end
        PRESETn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(2'b11);
            e = expv();
            if (got0 !== e || got1 !== e) begin
                bad++; $display("FAIL reset_post i=%0d got0=%b got1=%b exp=%b", i, got0, got1, e);
            end
            total++;
            if (i <= 4) begin
                if (if0.tick !== (i == 3) || if0.btn_db !== 2'b00 || if0.btn_press !== 2'b00) begin
                    bad++; $display("FAIL reset_first_tick i=%0d tick=%b db=%b press=%b", i, if0.tick, if0.btn_db, if0.btn_press);
                end
                total++;
            end
        end
    endtask

    task automatic test_clean_press();
        logic [6:0] e;
        int lat, presses;
        bit db1_seen;
        do_reset();
        for (int i = 0; i < 6; i++) step(2'b00);
        lat = 0; presses = 0; db1_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            step(2'b01);
            e = expv();
            if (got0 !== e || got1 !== e) begin
                bad++; $display("FAIL clean_press i=%0d got0=%b got1=%b exp=%b", i, got0, got1, e);
            end
            total++;
            if (if0.btn_db[0] === 1'b1 && lat == 0) lat = i;
            if (if0.btn_press[0] === 1'b1) presses++;
            if (if0.btn_db[1] !== 1'b0) db1_seen = 1;
        end
        if (lat < 1 || lat > 2 + ST * TD || presses != 1 || db1_seen) begin
            bad++; $display("FAIL clean_press_summary lat=%0d presses=%0d db1=%0d need lat<=%0d presses=1 db1=0",
                            lat, presses, db1_seen, 2 + ST * TD);
        end
        total++;
    endtask

    task automatic test_bounce();
        logic [6:0] e;
        logic [5:0] seq;
        int presses;
        seq = 6'b111011; // sampled LSB first: 1,1,0,1,1,1
        presses = 0;
        do_reset();
        for (int i = 0; i < 5; i++) step(2'b00);
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < TD; k++) begin
                step({1'b0, (w < 6) ? seq[w] : 1'b1});
                e = expv();
                if (got0 !== e || got1 !== e) begin
                    bad++; $display("FAIL bounce w=%0d k=%0d got0=%b got1=%b exp=%b", w, k, got0, got1, e);
                end
                total++;
                if (if0.btn_press[0] === 1'b1) presses++;
            end
            if (w == 4 && if0.btn_db[0] !== 1'b0) begin
                bad++; $display("FAIL bounce_early db0=%b exp=0", if0.btn_db[0]);
            end
            if (w == 4) total++;
        end
        if (if0.btn_db[0] !== 1'b1 || presses != 1) begin
            bad++; $display("FAIL bounce_final db0=%b presses=%0d exp db0=1 presses=1", if0.btn_db[0], presses);
        end
        total++;
    endtask

    task automatic test_glitch();
        logic [6:0] e;
        bit seen;
        do_reset();
        for (int i = 0; i < int'($urandom_range(3, 6)); i++) step(2'b00);
        while (((m_edges + 2) % TD) == TD - 1) step(2'b00);
        step(2'b10);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(2'b00);
            e = expv();
            if (got0 !== e || got1 !== e) begin
                bad++; $display("FAIL glitch i=%0d got0=%b got1=%b exp=%b", i, got0, got1, e);
            end
            total++;
            if (if0.btn_db[1] !== 1'b0 || if0.btn_press[1] !== 1'b0 || if0.btn_release[1] !== 1'b0) seen = 1;
        end
        if (seen) begin
            bad++; $display("FAIL glitch_filter activity=1 exp=0");
        end
        total++;
    endtask

    task automatic test_simultaneous();
        logic [6:0] e;
        int rel0_at, prs1_at, rel0_at1, prs1_at1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(2'b00);
            if (if1.btn_db !== 2'b00) begin
                bad++; $display("FAIL invert_idle db=%b exp=00", if1.btn_db);
            end
            total++;
        end
        for (int i = 0; i < 20; i++) step(2'b01);
        rel0_at = -1; prs1_at = -2; rel0_at1 = -3; prs1_at1 = -4;
        for (int i = 0; i < 20; i++) begin
            step(2'b10);
            e = expv();
            if (got0 !== e || got1 !== e) begin
                bad++; $display("FAIL simultaneous i=%0d got0=%b got1=%b exp=%b", i, got0, got1, e);
            end
            total++;
            if (if0.btn_release[0] === 1'b1) rel0_at = i;
            if (if0.btn_press[1] === 1'b1)   prs1_at = i;
            if (if1.btn_release[0] === 1'b1) rel0_at1 = i;
            if (if1.btn_press[1] === 1'b1)   prs1_at1 = i;
        end
        if (rel0_at != prs1_at || rel0_at1 != prs1_at1 || rel0_at < 0) begin
            bad++; $display("FAIL simultaneous_align rel0=%0d prs1=%0d rel0_inv=%0d prs1_inv=%0d exp equal",
                            rel0_at, prs1_at, rel0_at1, prs1_at1);
        end
        total++;
    endtask

    task automatic test_reset_mid_verify();
        logic [6:0] e;
        int guard, lat, presses;
        do_reset();
        for (int i = 0; i < 3; i++) step(2'b00);
        guard = 0;
        while (m_run[0] != 2 && guard < 40) begin
            step(2'b01);
            guard++;
        end
        if (guard >= 40) begin
            bad++; $display("FAIL mid_verify_setup timeout run=%0d exp=2", m_run[0]);
        end
        total++;
        #2;
        PRESETn = 1'b0;
        mreset();
        #1;
        if (got0 !== 7'd0 || got1 !== 7'd0) begin
            bad++; $display("FAIL mid_verify_async got0=%b got1=%b exp=0", got0, got1);
        end
        total++;
        step(2'b01);
        step(2'b01);
        PRESETn = 1'b1;
        lat = 0; presses = 0;
        for (int i = 1; i <= 20; i++) begin
            step(2'b01);
            e = expv();
            if (got0 !== e || got1 !== e) begin
                bad++; $display("FAIL mid_verify i=%0d got0=%b got1=%b exp=%b", i, got0, got1, e);
            end
            total++;
            if (if0.btn_press[0] === 1'b1) presses++;
            if (if0.btn_db[0] === 1'b1 && lat == 0) lat = i;
        end
        if (lat != ST * TD || presses != 1) begin
            bad++; $display("FAIL mid_verify_fresh lat=%0d presses=%0d exp lat=%0d presses=1", lat, presses, ST * TD);
        end
        total++;
    endtask

    task automatic test_random();
        logic [6:0] e;
        logic [1:0] r;
        int hold;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            r = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 20);
            if ($urandom_range(0, 29) == 0) begin
                #2;
                PRESETn = 1'b0;
                mreset();
                step(r);
                PRESETn = 1'b1;
            end
            for (int k = 0; k < hold; k++) begin
                step(r);
                e = expv();
                if (got0 !== e || got1 !== e) begin
                    bad++; $display("FAIL random n=%0d k=%0d raw=%b got0=%b got1=%b exp=%b", n, k, r, got0, got1, e);
                end
                total++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0;
        if0.btn_raw = 2'b00;
        if1.btn_raw = 2'b11;
        mreset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_verify();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
